alu_ctrl: RTL and testbench
===========================

// Module: alu_ctrl
// PURPOSE
//  Sequencer directly upstream of the 4-bit ALU: accepts encoded instructions via valid/ready,
//  reads operands from an internal register bank, drives A/B/ALUOp/L of the combinational ALU
//  (instantiated alongside in the parent), latches R and zero/carry/sign, writes back result.
//  Sits between instruction source (testbench/ROM) and the ALU in the practical's datapath top.
// PARAMETERS
//  DW    4  data width; must equal ALU width (4)
//  NREG  4  register bank entries (r0..r3); index width 2
// PORTS
//  clk         in   1   clock, rising edge
//  reset       in   1   asynchronous, active-low reset
//  in_valid    in   1   instruction present
//  in_ready    out  1   block can accept instruction
//  instr       in   12  [11]kind(0=ALU,1=LDI) [10]L [9:8]ALUOp [7:6]rd [5:4]ra [3:2]rb; LDI imm=[3:0]
//  alu_A       out  DW  ALU operand A (registered)
//  alu_B       out  DW  ALU operand B (registered)
//  alu_op      out  2   ALU ALUOp (registered)
//  alu_L       out  1   ALU logic/arith select (registered)
//  alu_R       in   DW  ALU result
//  alu_zero    in   1   ALU zero flag
//  alu_carry   in   1   ALU carry flag
//  alu_sign    in   1   ALU sign flag (R[3])
//  res         out  DW  last written-back value
//  done        out  1   one-cycle pulse: instruction retired, res valid
//  flags       out  3   {Z,C,S} architectural flag register
//  dbg_sel     in   2   debug register index
//  dbg_data    out  DW  combinational read of reg[dbg_sel]
// BEHAVIOUR
//  - reset low (async): state=IDLE, all regs/alu_A/alu_B/alu_op/alu_L/res/flags=0, done=0, in_ready=1
//  - FSM: IDLE, READ, EXEC, WB. in_ready=1 only in IDLE; accept = in_valid & in_ready
//  - IDLE: on accept latch instr. kind=1 (LDI) -> WB; kind=0 -> READ. No accept -> stay
//  - READ: alu_A<=reg[ra], alu_B<=reg[rb], alu_op<=ALUOp, alu_L<=L -> EXEC
//  - EXEC: ALU settled; capture alu_R, {zero,carry,sign} into internal latches -> WB
//  - WB: reg[rd]<=value (alu_R latch or imm), res<=value, done=1 this cycle; ALU instr updates
//    flags<={Z,C,S}; LDI leaves flags unchanged -> IDLE
//  - Latency accept->done: ALU 3 cycles, LDI 1 cycle; throughput one instr per 4 (ALU) / 2 (LDI)
//  - in_valid while not in_ready: ignored, not buffered; source must hold until accepted
//  - instr[1:0] ignored for ALU; instr[10:4] bits other than rd ignored for LDI
//  - rd may equal ra/rb: operands sampled in READ, write in WB -> old values used
//  - dbg_data during WB shows pre-write value; new value visible next cycle
//  - arithmetic entirely in ALU; widths fixed DW, no extension, carry stored as produced
//  - alu_* outputs hold last values outside READ; no glitching to ALU mid-EXEC
//  - reset asserted mid-instruction: aborts, no done pulse, no partial write, regs cleared
// STRUCTURE
//  - shared include alu_defs.vh: state localparams (IDLE/READ/EXEC/WB), KIND_ALU/KIND_LDI,
//    instr field bit positions, ALUOp codes (ADD 00, SUB 01, NEGA 10, NEGB 11)
//  - one sub-module: regfile4x4 (NREG x DW, 1 write port, 3 async read ports: ra, rb, dbg)
//  - FSM, operand/ALU output regs, result/flag regs in alu_ctrl
// TESTING
//  - reset: after release in_ready=1, flags=000, dbg_data=0 for all dbg_sel, done=0
//  - LDI r1,5 ; LDI r2,3 -> each done after 1 cycle, dbg(1)=5, dbg(2)=3, flags unchanged 000
//  - ADD r0=r1+r2 -> done 3 cycles after accept, res=8, alu_A=5 alu_B=3, flags Z0 C0 S1
//  - SUB r3=r1-r1 -> res=0, flags Z1 C1 S0; NEGA r2=-r1 (ALUOp 10) -> res=11, flags Z0 C0 S1
//  - in_valid held high back-to-back 2 ADDs -> 2nd accepted only in IDLE after 1st done,
//    exactly one done per instr, in_ready low during READ/EXEC/WB
//  - reset pulled low during EXEC of ADD r0 -> no done, r0=0, flags=000, FSM in IDLE after release

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU sequencer: widths, instruction layout,
// ALUOp codes and FSM state encoding.
package alu_ctrl_pkg;

    localparam int DW   = 4;
    localparam int NREG = 4;
    localparam int AW   = 2;
    localparam int IW   = 12;

    localparam logic KIND_ALU = 1'b0;
    localparam logic KIND_LDI = 1'b1;

    typedef enum logic [1:0] {
        ALU_ADD  = 2'b00,
        ALU_SUB  = 2'b01,
        ALU_NEGA = 2'b10,
        ALU_NEGB = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_READ = 2'b01,
        S_EXEC = 2'b10,
        S_WB   = 2'b11
    } state_e;

    // Field order mirrors instr[11:0]; the LDI immediate overlays rb and the low pair.
    typedef struct packed {
        logic          kind;
        logic          l;
        alu_op_e       op;
        logic [AW-1:0] rd;
        logic [AW-1:0] ra;
        logic [AW-1:0] rb;
        logic [1:0]    lo;
    } instr_t;

    function automatic logic [DW-1:0] ldi_imm(input instr_t i);
        return {i.rb, i.lo};
    endfunction

endpackage

// File: rtl/alu_ctrl_if.sv
// Instruction handshake between an instruction source and the ALU sequencer.
interface alu_ctrl_if;
    import alu_ctrl_pkg::*;

    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] instr;

    modport master (output in_valid, output instr, input in_ready);
    modport slave  (input in_valid, input instr, output in_ready);

endinterface

// File: rtl/alu_ctrl_regfile4x4.sv
// Small register bank: one synchronous write port, three asynchronous read ports.
module regfile4x4 #(
    parameter int DW   = 4,
    parameter int NREG = 4,
    parameter int AW   = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    input  logic [AW-1:0] ra_a,
    input  logic [AW-1:0] ra_b,
    input  logic [AW-1:0] ra_dbg,
    output logic [DW-1:0] rd_a,
    output logic [DW-1:0] rd_b,
    output logic [DW-1:0] rd_dbg
);

    logic [DW-1:0] mem [NREG];

    // Reads are combinational, so a same-cycle read sees the value before the write lands.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[wa] <= wd;
        end
    end

    assign rd_a   = mem[ra_a];
    assign rd_b   = mem[ra_b];
    assign rd_dbg = mem[ra_dbg];

endmodule

// File: rtl/alu_ctrl.sv
// Sequencer in front of the 4-bit combinational ALU: fetches operands, drives the ALU,
// captures result and flags, and writes back. reset is asynchronous and active-low.
module alu_ctrl
    import alu_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    alu_ctrl_if.slave       in_bus,
    output logic [DW-1:0]   alu_A,
    output logic [DW-1:0]   alu_B,
    output logic [1:0]      alu_op,
    output logic            alu_L,
    input  logic [DW-1:0]   alu_R,
    input  logic            alu_zero,
    input  logic            alu_carry,
    input  logic            alu_sign,
    output logic [DW-1:0]   res,
    output logic            done,
    output logic [2:0]      flags,
    input  logic [AW-1:0]   dbg_sel,
    output logic [DW-1:0]   dbg_data
);

    state_e        state;
    state_e        next_state;
    instr_t        instr_q;
    logic [DW-1:0] r_q;
    logic [2:0]    f_q;
    logic [DW-1:0] res_q;
    logic [DW-1:0] wb_value;
    logic [DW-1:0] rd_a;
    logic [DW-1:0] rd_b;
    logic          ready;
    logic          we;
    logic          accept;

    regfile4x4 #(.DW(DW), .NREG(NREG), .AW(AW)) u_regfile (
        .clk    (clk),
        .reset  (reset),
        .we     (we),
        .wa     (instr_q.rd),
        .wd     (wb_value),
        .ra_a   (instr_q.ra),
        .ra_b   (instr_q.rb),
        .ra_dbg (dbg_sel),
        .rd_a   (rd_a),
        .rd_b   (rd_b),
        .rd_dbg (dbg_data)
    );

    assign in_bus.in_ready = ready;
    assign accept          = in_bus.in_valid & ready;
    assign wb_value        = (instr_q.kind == KIND_LDI) ? ldi_imm(instr_q) : r_q;
    // res tracks the retiring value during the done cycle, then holds it.
    assign res             = (state == S_WB) ? wb_value : res_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        ready      = 1'b0;
        done       = 1'b0;
        we         = 1'b0;
        case (state)
            S_IDLE: begin
                ready = 1'b1;
                if (in_bus.in_valid) begin
                    next_state = (in_bus.instr[IW-1] == KIND_LDI) ? S_WB : S_READ;
                end
            end
            S_READ: next_state = S_EXEC;
            S_EXEC: next_state = S_WB;
            S_WB: begin
                done       = 1'b1;
                we         = 1'b1;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // ALU inputs only change in READ, so the ALU sees stable operands through EXEC.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_q <= '0;
            alu_A   <= '0;
            alu_B   <= '0;
            alu_op  <= '0;
            alu_L   <= 1'b0;
            r_q     <= '0;
            f_q     <= '0;
            res_q   <= '0;
            flags   <= '0;
        end else begin
            if (accept) begin
                instr_q <= instr_t'(in_bus.instr);
            end
            if (state == S_READ) begin
                alu_A  <= rd_a;
                alu_B  <= rd_b;
                alu_op <= instr_q.op;
                alu_L  <= instr_q.l;
            end
            if (state == S_EXEC) begin
                r_q <= alu_R;
                f_q <= {alu_zero, alu_carry, alu_sign};
            end
            if (state == S_WB) begin
                res_q <= wb_value;
                if (instr_q.kind == KIND_ALU) begin
                    flags <= f_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_ctrl.sv
// Directed bench for alu_ctrl with a behavioural 4-bit ALU standing in for the real one.
module tb_alu_ctrl;
    import alu_ctrl_pkg::*;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] alu_A;
    logic [DW-1:0] alu_B;
    logic [1:0]    alu_op;
    logic          alu_L;
    logic [DW-1:0] alu_R;
    logic          alu_zero;
    logic          alu_carry;
    logic          alu_sign;
    logic [DW-1:0] res;
    logic          done;
    logic [2:0]    flags;
    logic [AW-1:0] dbg_sel;
    logic [DW-1:0] dbg_data;
    logic [4:0]    sum;

    int checks = 0;
    int errors = 0;

    alu_ctrl_if bus ();

    alu_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .in_bus    (bus.slave),
        .alu_A     (alu_A),
        .alu_B     (alu_B),
        .alu_op    (alu_op),
        .alu_L     (alu_L),
        .alu_R     (alu_R),
        .alu_zero  (alu_zero),
        .alu_carry (alu_carry),
        .alu_sign  (alu_sign),
        .res       (res),
        .done      (done),
        .flags     (flags),
        .dbg_sel   (dbg_sel),
        .dbg_data  (dbg_data)
    );

    always #5 clk = ~clk;

    // Subtraction and negation use A + ~B + 1, so carry means "no borrow".
    always_comb begin
        sum = '0;
        if (!alu_L) begin
            case (alu_op)
                2'b00:   sum = {1'b0, alu_A} + {1'b0, alu_B};
                2'b01:   sum = {1'b0, alu_A} + {1'b0, ~alu_B} + 5'd1;
                2'b10:   sum = {1'b0, ~alu_A} + 5'd1;
                default: sum = {1'b0, ~alu_B} + 5'd1;
            endcase
        end else begin
            case (alu_op)
                2'b00:   sum = {1'b0, alu_A & alu_B};
                2'b01:   sum = {1'b0, alu_A | alu_B};
                2'b10:   sum = {1'b0, alu_A ^ alu_B};
                default: sum = {1'b0, ~alu_A};
            endcase
        end
    end

    assign alu_R     = sum[3:0];
    assign alu_carry = sum[4];
    assign alu_zero  = (sum[3:0] == 4'd0);
    assign alu_sign  = sum[3];

    function automatic logic [11:0] enc_ldi(input logic [1:0] rd, input logic [3:0] imm);
        return {1'b1, 1'b0, 2'b00, rd, 2'b00, imm};
    endfunction

    function automatic logic [11:0] enc_alu(input logic [1:0] op, input logic [1:0] rd,
                                            input logic [1:0] ra, input logic [1:0] rb);
        return {1'b0, 1'b0, op, rd, ra, rb, 2'b00};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Issues one instruction, then checks accept->done latency and res on the done cycle.
    task automatic applyStimulus(input logic [11:0] ins, input string tag,
                                 input int exp_lat, input logic [3:0] exp_res);
        int wait_cycles;
        int lat;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.instr    = ins;
        #1;
        wait_cycles = 0;
        while (!bus.in_ready && wait_cycles < 16) begin
            @(negedge clk);
            #1;
            wait_cycles++;
        end
        checkOutput({tag, "_accept"}, 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (lat < 12) begin
            @(negedge clk);
            #1;
            lat++;
            if (done) break;
        end
        checkOutput({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        checkOutput({tag, "_res"}, 32'(res), 32'(exp_res));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] ready_exp;
        logic [7:0] done_exp;
        int         done_count;

        reset        = 1'b0;
        bus.in_valid = 1'b0;
        bus.instr    = '0;
        dbg_sel      = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("rst_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("rst_flags", 32'(flags), 32'b000);
        checkOutput("rst_done",  32'(done), 32'd0);
        for (int i = 0; i < NREG; i++) begin
            dbg_sel = AW'(i);
            #1;
            checkOutput($sformatf("rst_dbg%0d", i), 32'(dbg_data), 32'd0);
        end

        applyStimulus(enc_ldi(2'd1, 4'd5), "ldi_r1", 1, 4'd5);
        @(negedge clk); #1;
        dbg_sel = 2'd1; #1;
        checkOutput("dbg_r1", 32'(dbg_data), 32'd5);

        dbg_sel = 2'd2;
        applyStimulus(enc_ldi(2'd2, 4'd3), "ldi_r2", 1, 4'd3);
        checkOutput("dbg_r2_prewrite", 32'(dbg_data), 32'd0);
        @(negedge clk); #1;
        checkOutput("dbg_r2", 32'(dbg_data), 32'd3);
        checkOutput("ldi_flags", 32'(flags), 32'b000);

        applyStimulus(enc_alu(2'b00, 2'd0, 2'd1, 2'd2), "add_r0", 3, 4'd8);
        checkOutput("add_alu_A", 32'(alu_A), 32'd5);
        checkOutput("add_alu_B", 32'(alu_B), 32'd3);
        checkOutput("add_alu_op", 32'(alu_op), 32'd0);
        @(negedge clk); #1;
        checkOutput("add_flags", 32'(flags), 32'b001);
        checkOutput("add_res_hold", 32'(res), 32'd8);

        applyStimulus(enc_alu(2'b01, 2'd3, 2'd1, 2'd1) | 12'b11, "sub_r3", 3, 4'd0);
        @(negedge clk); #1;
        checkOutput("sub_flags", 32'(flags), 32'b110);

        applyStimulus(enc_alu(2'b10, 2'd2, 2'd1, 2'd0), "nega_r2", 3, 4'd11);
        checkOutput("nega_alu_op", 32'(alu_op), 32'd2);
        @(negedge clk); #1;
        checkOutput("nega_flags", 32'(flags), 32'b001);
        dbg_sel = 2'd2; #1;
        checkOutput("dbg_r2_nega", 32'(dbg_data), 32'd11);

        dbg_sel = 2'd1;
        applyStimulus(enc_alu(2'b00, 2'd1, 2'd1, 2'd1), "add_r1_self", 3, 4'd10);
        checkOutput("self_prewrite", 32'(dbg_data), 32'd5);
        @(negedge clk); #1;
        checkOutput("self_postwrite", 32'(dbg_data), 32'd10);

        applyStimulus(12'b1_1_11_11_11_0000, "ldi_r3_junk", 1, 4'd0);
        @(negedge clk); #1;
        checkOutput("ldi_keeps_flags", 32'(flags), 32'b001);

        // in_valid stays high across two ADDs; the second waits for IDLE.
        ready_exp  = 8'b0001_0001;
        done_exp   = 8'b1000_1000;
        done_count = 0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            if (i == 0) begin
                bus.in_valid = 1'b1;
                bus.instr    = enc_alu(2'b00, 2'd0, 2'd1, 2'd2);
            end
            #1;
            checkOutput($sformatf("b2b_ready%0d", i), 32'(bus.in_ready), 32'(ready_exp[i]));
            checkOutput($sformatf("b2b_done%0d", i), 32'(done), 32'(done_exp[i]));
            if (done) done_count++;
            if (i == 3) begin
                checkOutput("b2b_res1", 32'(res), 32'd5);
                bus.instr = enc_alu(2'b00, 2'd3, 2'd0, 2'd0);
            end
            if (i == 4) checkOutput("b2b_flags1", 32'(flags), 32'b010);
            if (i == 7) begin
                checkOutput("b2b_res2", 32'(res), 32'd10);
                bus.in_valid = 1'b0;
            end
        end
        @(negedge clk); #1;
        checkOutput("b2b_done_count", 32'(done_count), 32'd2);
        checkOutput("b2b_flags2", 32'(flags), 32'b001);
        checkOutput("b2b_idle_ready", 32'(bus.in_ready), 32'd1);

        // Reset lands during EXEC of an ADD: the instruction must vanish without trace.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.instr    = enc_alu(2'b00, 2'd0, 2'd1, 2'd2);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        done_count = 0;
        checkOutput("abort_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("abort_done", 32'(done), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            if (done) done_count++;
        end
        checkOutput("abort_no_done", 32'(done_count), 32'd0);
        checkOutput("abort_flags", 32'(flags), 32'b000);
        checkOutput("abort_alu_A", 32'(alu_A), 32'd0);
        checkOutput("abort_ready_after", 32'(bus.in_ready), 32'd1);
        dbg_sel = 2'd0; #1;
        checkOutput("abort_r0", 32'(dbg_data), 32'd0);
        dbg_sel = 2'd1; #1;
        checkOutput("abort_r1", 32'(dbg_data), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
